// File: rtl/zigbee_cordic_arbiter.sv
// ============================================================================
//  Module   : zigbee_cordic_arbiter
//  Function : Round-robin time-sharing of one CORDIC phase engine between
//             NUM_REQ I/Q streams. Each result is returned with its requester ID.
//  Option   : ZIGBEE_CORDIC_ARB_STATS_EN adds per-requester grant counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module zigbee_cordic_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int IQ_SIZE    = 5,
    parameter int W_SIZE     = 6,
    parameter int CORDIC_LAT = 3,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*IQ_SIZE-1:0] req_ibb,
    input  logic [NUM_REQ*IQ_SIZE-1:0] req_qbb,
    output logic [IQ_SIZE-1:0]         cor_ibb,
    output logic [IQ_SIZE-1:0]         cor_qbb,
    output logic                       cor_ivalid,
    input  logic [W_SIZE-1:0]          cor_wout,
    input  logic                       cor_ovalid,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [W_SIZE-1:0]          res_w,
    output logic                       busy,
`ifdef ZIGBEE_CORDIC_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]      stat_grant_cnt,
`endif
    output logic                       err_desync
);

    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] w_ptr;
    logic [ID_W-1:0] w_cand;
    logic [ID_W-1:0] w_gnt_id;
    logic            w_gnt_any;
    logic [ID_W-1:0] r_issue_id;

    logic [CORDIC_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]       r_tag_id [CORDIC_LAT];
    logic                  w_tail_vld;
    logic [ID_W-1:0]       w_tail_id;

    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Search upward from the pointer; an out-of-range pointer restarts at 0.
    always_comb begin
        w_ptr     = (int'(r_rr_ptr) < NUM_REQ) ? r_rr_ptr : '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_cand    = '0;
        req_ready = '0;
        if (arb_en && reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                w_cand = f_wrap(w_ptr, i);
                if (!w_gnt_any && req_valid[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = w_cand;
                end
            end
        end
        if (w_gnt_any) req_ready[w_gnt_id] = 1'b1;
    end

    assign w_tail_vld = r_tag_vld[CORDIC_LAT-1];
    assign w_tail_id  = r_tag_id[CORDIC_LAT-1];
    assign busy       = cor_ivalid | (|r_tag_vld) | res_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_issue_id <= '0;
            cor_ibb    <= '0;
            cor_qbb    <= '0;
            cor_ivalid <= 1'b0;
            r_tag_vld  <= '0;
            for (int s = 0; s < CORDIC_LAT; s++) r_tag_id[s] <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_w      <= '0;
            err_desync <= 1'b0;
        end else begin
            cor_ivalid <= w_gnt_any;
            r_issue_id <= w_gnt_id;
            if (w_gnt_any) begin
                cor_ibb  <= req_ibb[w_gnt_id*IQ_SIZE +: IQ_SIZE];
                cor_qbb  <= req_qbb[w_gnt_id*IQ_SIZE +: IQ_SIZE];
                r_rr_ptr <= f_wrap(w_gnt_id, 1);
            end
            // Tag stage 0 trails cor_ivalid by one cycle so the tail meets cor_ovalid.
            r_tag_vld[0] <= cor_ivalid;
            r_tag_id[0]  <= r_issue_id;
            for (int s = 1; s < CORDIC_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
            res_valid <= cor_ovalid;
            if (cor_ovalid) begin
                res_w  <= cor_wout;
                res_id <= w_tail_vld ? w_tail_id : '0;
            end
            if (cor_ovalid != w_tail_vld) err_desync <= 1'b1;
        end
    end

`ifdef ZIGBEE_CORDIC_ARB_STATS_EN
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    r_cnt <= '0;
                else if (req_ready[k] && (r_cnt != 16'hFFFF))
                    r_cnt <= r_cnt + 16'd1;
            end
            assign stat_grant_cnt[k*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_zigbee_cordic_arbiter.sv
// ============================================================================
//  Module   : tb_zigbee_cordic_arbiter
//  Function : Randomized bench with a queue-based reference model and a
//             fixed-latency CORDIC stand-in.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_zigbee_cordic_arbiter;

    localparam int N   = 2;
    localparam int IQ  = 5;
    localparam int W   = 6;
    localparam int LAT = 3;

    logic            clk;
    logic            reset_n;
    logic            arb_en;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*IQ-1:0] req_ibb;
    logic [N*IQ-1:0] req_qbb;
    logic [IQ-1:0]   cor_ibb;
    logic [IQ-1:0]   cor_qbb;
    logic            cor_ivalid;
    logic [W-1:0]    cor_wout;
    logic            cor_ovalid;
    logic            res_valid;
    logic [0:0]      res_id;
    logic [W-1:0]    res_w;
    logic            busy;
    logic            err_desync;
`ifdef ZIGBEE_CORDIC_ARB_STATS_EN
    logic [N*16-1:0] stat_grant_cnt;
`endif

    zigbee_cordic_arbiter #(
        .NUM_REQ(N), .IQ_SIZE(IQ), .W_SIZE(W), .CORDIC_LAT(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ibb(req_ibb), .req_qbb(req_qbb),
        .cor_ibb(cor_ibb), .cor_qbb(cor_qbb), .cor_ivalid(cor_ivalid),
        .cor_wout(cor_wout), .cor_ovalid(cor_ovalid),
        .res_valid(res_valid), .res_id(res_id), .res_w(res_w),
        .busy(busy),
`ifdef ZIGBEE_CORDIC_ARB_STATS_EN
        .stat_grant_cnt(stat_grant_cnt),
`endif
        .err_desync(err_desync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] fake_phase(input logic [IQ-1:0] i, input logic [IQ-1:0] q);
        return W'(int'($signed(i)) * 3 + int'($signed(q)));
    endfunction

    // Stand-in CORDIC: fixed LAT-cycle valid/phase pipeline plus a spurious-result injector.
    logic [LAT-1:0] p_v;
    logic [W-1:0]   p_w [LAT];
    logic           inj;
    logic [W-1:0]   inj_w;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_v <= '0;
        end else begin
            p_v  <= {p_v[LAT-2:0], cor_ivalid};
            p_w[0] <= fake_phase(cor_ibb, cor_qbb);
            for (int s = 1; s < LAT; s++) p_w[s] <= p_w[s-1];
        end
    end
    assign cor_ovalid = p_v[LAT-1] | inj;
    assign cor_wout   = inj ? inj_w : p_w[LAT-1];

    typedef struct {
        int           due;
        int           id;
        logic [W-1:0] w;
    } exp_t;

    exp_t          exp_q[$];
    int            cyc;
    int            m_rr;
    logic          m_ivalid;
    logic [IQ-1:0] m_ibb;
    logic [IQ-1:0] m_qbb;
    logic          m_err;
    int            m_cnt [N];
    int            n_vec;
    int            n_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit popped;
        popped = 1'b0;
        chk("cor_ivalid", 32'(cor_ivalid), 32'(m_ivalid));
        chk("cor_ibb", 32'(cor_ibb), 32'(m_ibb));
        chk("cor_qbb", 32'(cor_qbb), 32'(m_qbb));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_id", 32'(res_id), 32'(exp_q[0].id));
            chk("res_w", 32'(res_w), 32'(exp_q[0].w));
            void'(exp_q.pop_front());
            popped = 1'b1;
        end else begin
            chk("res_valid_idle", 32'(res_valid), 32'd0);
        end
        chk("busy", 32'(busy), 32'((exp_q.size() > 0) || popped));
        chk("err_desync", 32'(err_desync), 32'(m_err));
    endtask

    // Called one time unit after an active edge: drive, check grant, advance one cycle, check.
    task automatic step(input logic [N-1:0] vmask, input bit en, input bit inj_now,
                        input logic [N*IQ-1:0] ib, input logic [N*IQ-1:0] qb);
        int   g;
        int   k;
        exp_t e;
        req_valid = vmask;
        arb_en    = en;
        req_ibb   = ib;
        req_qbb   = qb;
        inj       = inj_now;
        inj_w     = W'($urandom);
        #1;
        g = -1;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (g < 0 && vmask[k]) g = k;
            end
        end
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) begin
            m_ivalid = 1'b1;
            m_ibb    = ib[g*IQ +: IQ];
            m_qbb    = qb[g*IQ +: IQ];
            e.due = cyc + LAT + 2;
            e.id  = g;
            e.w   = fake_phase(m_ibb, m_qbb);
            exp_q.push_back(e);
            m_rr = (g + 1) % N;
            m_cnt[g]++;
        end else begin
            m_ivalid = 1'b0;
        end
        if (inj_now) begin
            e.due = cyc + 1;
            e.id  = 0;
            e.w   = inj_w;
            exp_q.push_front(e);
            m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        inj = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
    endtask

    task automatic clear_model();
        exp_q.delete();
        m_rr     = 0;
        m_ivalid = 1'b0;
        m_ibb    = '0;
        m_qbb    = '0;
        m_err    = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Reset asserted between edges with requesters still valid; everything must drop at once.
    task automatic do_reset();
        req_valid = '1;
        arb_en    = 1'b1;
        reset_n   = 1'b0;
        #1;
        clear_model();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_cor_ivalid", 32'(cor_ivalid), 32'd0);
        chk("rst_cor_ibb", 32'(cor_ibb), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_w", 32'(res_w), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_desync), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        reset_n = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        cyc       = 0;
        inj       = 1'b0;
        inj_w     = '0;
        req_valid = '0;
        arb_en    = 1'b0;
        req_ibb   = '0;
        req_qbb   = '0;
        reset_n   = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single requester 0 with I=-3, Q=+4.
        step(2'b01, 1'b1, 1'b0, {5'd0, 5'h1D}, {5'd0, 5'd4});
        idle(6);

        // Both requesters held: alternating grants.
        for (int i = 0; i < 8; i++) step(2'b11, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        idle(6);

        // Requester 1 alone, back to back.
        for (int i = 0; i < 5; i++) step(2'b10, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        idle(6);

        for (int i = 0; i < 300; i++)
            step(N'($urandom), ($urandom_range(0, 7) != 0), 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        idle(6);

        // Two grants, then arb_en low: drain and let busy fall.
        step(2'b11, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        step(2'b11, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        for (int i = 0; i < 8; i++) step(2'b11, 1'b0, 1'b0, N*IQ'($urandom), N*IQ'($urandom));

`ifdef ZIGBEE_CORDIC_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("stat_grant_cnt", 32'(stat_grant_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif

        // Spurious result with an empty tag pipeline; sticky until reset.
        step('0, 1'b1, 1'b1, N*IQ'($urandom), N*IQ'($urandom));
        idle(4);
        do_reset();
        idle(2);

        // Reset with two samples in flight: nothing may emerge afterwards.
        step(2'b11, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        step(2'b11, 1'b1, 1'b0, N*IQ'($urandom), N*IQ'($urandom));
        do_reset();
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
